// File: rtl/icache_refill.sv
// icache_refill: fetches one I-cache line word by word from instruction memory and hands it back whole.
// Build option ICACHE_CRITICAL_WORD_FIRST_EN: fetch starts at the missing word and forwards it on crit_*.
module icache_refill #(
    parameter int TEXT_BITS  = 12,
    parameter int LINE_WORDS = 4,
    localparam int AW        = TEXT_BITS - 2,
    localparam int OFF_BITS  = $clog2(LINE_WORDS),
    localparam int IW        = AW - OFF_BITS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [AW-1:0]            req_addr,
    input  logic                     flush,
    output logic                     mem_ren,
    output logic [AW-1:0]            mem_addr,
    input  logic [31:0]              mem_dout,
    output logic                     fill_valid,
    input  logic                     fill_ready,
    output logic [IW-1:0]            fill_addr,
    output logic [32*LINE_WORDS-1:0] fill_line,
    output logic                     crit_valid,
    output logic [31:0]              crit_data
);

    // state | meaning
    // IDLE  | waiting for a miss request
    // FETCH | one memory read per cycle, LINE_WORDS cycles
    // DONE  | full line offered on fill_*, waiting for fill_ready

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

    state_t                     state, state_nxt;
    logic [IW-1:0]              line_idx;
    logic [OFF_BITS-1:0]        start_off, cnt, slot, req_start;
    logic [AW-1:0]              cur_addr, last_addr;
    logic [32*LINE_WORDS-1:0]   line_q;
    logic                       last_word;

    // Offset arithmetic is OFF_BITS wide so it wraps inside the line and never touches the index.
    assign slot      = start_off + cnt;
    assign cur_addr  = {line_idx, slot};
    assign last_word = (cnt == OFF_BITS'(LINE_WORDS - 1));
    assign req_start = req_addr[OFF_BITS-1:0] & {OFF_BITS{CWF}};

    assign mem_addr  = (state == FETCH) ? cur_addr : last_addr;
    assign fill_addr = line_idx;
    assign fill_line = line_q;

    assign crit_valid = CWF && (state == FETCH) && (cnt == '0);
    assign crit_data  = crit_valid ? mem_dout : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        mem_ren    = 1'b0;
        fill_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = FETCH;
            end
            FETCH: begin
                mem_ren = 1'b1;
                if (last_word) state_nxt = DONE;
            end
            DONE: begin
                fill_valid = 1'b1;
                if (fill_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            line_idx  <= '0;
            start_off <= '0;
            cnt       <= '0;
            last_addr <= '0;
            line_q    <= '0;
        end else begin
            if (state == FETCH) last_addr <= cur_addr;
            if (flush) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid) begin
                            line_idx  <= req_addr[AW-1:OFF_BITS];
                            start_off <= req_start;
                            cnt       <= '0;
                        end
                    end
                    // Counter rolls over to zero on the last word, ready for the next line.
                    FETCH: begin
                        line_q[32*slot +: 32] <= mem_dout;
                        cnt                   <= cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Bench for icache_refill: directed test-plan sequences plus random traffic against a transaction-level model.
module tb_icache_refill;
    localparam int TEXT_BITS  = 12;
    localparam int LINE_WORDS = 4;
    localparam int AW  = TEXT_BITS - 2;
    localparam int OFF = 2;
    localparam int IW  = AW - OFF;
    localparam int LW  = 32 * LINE_WORDS;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, flush, mem_ren, fill_valid, fill_ready, crit_valid;
    logic [AW-1:0] req_addr, mem_addr;
    logic [31:0]   mem_dout, crit_data;
    logic [IW-1:0] fill_addr;
    logic [LW-1:0] fill_line;

    icache_refill #(.TEXT_BITS(TEXT_BITS), .LINE_WORDS(LINE_WORDS)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .fill_valid(fill_valid), .fill_ready(fill_ready),
        .fill_addr(fill_addr), .fill_line(fill_line),
        .crit_valid(crit_valid), .crit_data(crit_data)
    );

    always #5 clock = ~clock;

    // Preloaded memory: data[i] = 0x1000_0000 + i.
    assign mem_dout = 32'h1000_0000 + 32'(mem_addr);

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int first_fill = -1;

    // Model: a request is "in flight" for m_t cycles since acceptance.
    bit            m_busy = 1'b0;
    int            m_t = 0;
    int            m_start = 0;
    logic [AW-1:0] m_base = '0;
    logic [AW-1:0] m_last = '0;

    logic [AW-1:0] trace_addr[$];
    logic [31:0]   crit_seen[$];
    logic [IW-1:0] got_fill_addr[$];
    logic [LW-1:0] got_fill_line[$];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [LW-1:0] line_of(input logic [AW-1:0] base);
        logic [LW-1:0] l;
        l = '0;
        for (int i = 0; i < LINE_WORDS; i++)
            l[32*i +: 32] = 32'h1000_0000 + 32'(base) + 32'(i);
        return l;
    endfunction

    task automatic compare_cycle();
        bit            fetching, done, crit_exp;
        int            k;
        logic [AW-1:0] ea;
        k        = 0;
        fetching = m_busy && (m_t >= 1) && (m_t <= LINE_WORDS);
        done     = m_busy && (m_t > LINE_WORDS);
        if (fetching) begin
            k  = m_t - 1;
            ea = m_base + AW'((m_start + k) % LINE_WORDS);
        end else begin
            ea = m_last;
        end
        chk("req_ready",  LW'(req_ready),  LW'(!m_busy));
        chk("mem_ren",    LW'(mem_ren),    LW'(fetching));
        chk("fill_valid", LW'(fill_valid), LW'(done));
        chk("mem_addr",   LW'(mem_addr),   LW'(ea));
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        crit_exp = fetching && (k == 0);
        chk("crit_valid", LW'(crit_valid), LW'(crit_exp));
        if (crit_exp) chk("crit_data", LW'(crit_data), LW'(32'h1000_0000 + 32'(ea)));
`else
        crit_exp = 1'b0;
        chk("crit_valid", LW'(crit_valid), LW'(crit_exp));
        chk("crit_data",  LW'(crit_data),  LW'(0));
`endif
        if (done) begin
            chk("fill_addr", LW'(fill_addr), LW'(m_base[AW-1:OFF]));
            chk("fill_line", fill_line, line_of(m_base));
        end
        if (fetching) begin
            trace_addr.push_back(mem_addr);
            m_last = ea;
        end
        if (crit_valid) crit_seen.push_back(crit_data);
        if (fill_valid && first_fill < 0) first_fill = cyc;
    endtask

    task automatic update_model(input bit rv, input logic [AW-1:0] ra, input bit fl, input bit fr);
        if (fl) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (rv) begin
                m_busy  = 1'b1;
                m_t     = 1;
                m_base  = {ra[AW-1:OFF], {OFF{1'b0}}};
                m_start = CWF ? int'(ra[OFF-1:0]) : 0;
                acc_cyc = cyc;
            end
        end else if (m_t > LINE_WORDS) begin
            if (fr) begin
                m_busy = 1'b0;
                got_fill_addr.push_back(fill_addr);
                got_fill_line.push_back(fill_line);
            end
        end else begin
            m_t++;
        end
    endtask

    task automatic cycle(input bit rv, input logic [AW-1:0] ra, input bit fl, input bit fr);
        @(negedge clock);
        cyc++;
        compare_cycle();
        req_valid  = rv;
        req_addr   = ra;
        flush      = fl;
        fill_ready = fr;
        update_model(rv, ra, fl, fr);
        @(posedge clock);
    endtask

    task automatic clear_logs();
        trace_addr.delete();
        crit_seen.delete();
        got_fill_addr.delete();
        got_fill_line.delete();
        first_fill = -1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  LW'(req_ready),  LW'(1));
        chk({tag, "_mem_ren"},    LW'(mem_ren),    LW'(0));
        chk({tag, "_mem_addr"},   LW'(mem_addr),   LW'(0));
        chk({tag, "_fill_valid"}, LW'(fill_valid), LW'(0));
        chk({tag, "_fill_addr"},  LW'(fill_addr),  LW'(0));
        chk({tag, "_fill_line"},  fill_line,       LW'(0));
        chk({tag, "_crit_valid"}, LW'(crit_valid), LW'(0));
        chk({tag, "_crit_data"},  LW'(crit_data),  LW'(0));
    endtask

    logic [AW-1:0] exp_seq [LINE_WORDS];

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; flush = 1'b0; fill_ready = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Basic refill (ascending, or critical-word-first when enabled).
        clear_logs();
        cycle(1'b1, 10'h026, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, '0, 1'b0, 1'b1);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        exp_seq = '{10'h026, 10'h027, 10'h024, 10'h025};
        chk("crit_count", LW'(crit_seen.size()), LW'(1));
        chk("crit_word", LW'(crit_seen[0]), LW'(32'h1000_0026));
`else
        exp_seq = '{10'h024, 10'h025, 10'h026, 10'h027};
        chk("crit_count", LW'(crit_seen.size()), LW'(0));
`endif
        chk("seq_len", LW'(trace_addr.size()), LW'(4));
        for (int i = 0; i < LINE_WORDS; i++) chk("seq_addr", LW'(trace_addr[i]), LW'(exp_seq[i]));
        chk("latency", LW'(first_fill - acc_cyc), LW'(LINE_WORDS + 1));
        chk("basic_xfers", LW'(got_fill_addr.size()), LW'(1));
        chk("basic_addr", LW'(got_fill_addr[0]), LW'(8'h09));
        chk("basic_line", got_fill_line[0], 128'h10000027_10000026_10000025_10000024);

        // Back-to-back with fill_ready high: accept again LINE_WORDS+2 cycles later.
        clear_logs();
        cycle(1'b1, 10'h030, 1'b0, 1'b1);
        begin
            int a0;
            a0 = acc_cyc;
            for (int i = 0; i < 12 && acc_cyc == a0; i++) cycle(1'b1, 10'h034, 1'b0, 1'b1);
            chk("b2b_period", LW'(acc_cyc - a0), LW'(LINE_WORDS + 2));
        end
        cycle(1'b0, '0, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("b2b_xfers", LW'(got_fill_addr.size()), LW'(2));

        // Backpressure: line held, requests ignored, delivered once.
        clear_logs();
        cycle(1'b1, 10'h100, 1'b0, 1'b0);
        repeat (LINE_WORDS) cycle(1'b1, 10'h100, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 10'h104, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
        chk("bp_xfers", LW'(got_fill_addr.size()), LW'(1));
        chk("bp_addr", LW'(got_fill_addr[0]), LW'(8'h40));
        chk("bp_line", got_fill_line[0], 128'h10000103_10000102_10000101_10000100);

        // flush together with a request in IDLE: not accepted.
        cycle(1'b1, 10'h040, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Flush mid-FETCH, then a refill of the last line of text space.
        clear_logs();
        cycle(1'b1, 10'h010, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("flush_reads", LW'(trace_addr.size()), LW'(3));
        chk("flush_xfers", LW'(got_fill_addr.size()), LW'(0));
        trace_addr.delete();
        cycle(1'b1, 10'h3FC, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < LINE_WORDS; i++) chk("top_addr", LW'(trace_addr[i]), LW'(10'h3FC + 10'(i)));
        chk("top_fill_addr", LW'(got_fill_addr[0]), LW'(8'hFF));
        chk("top_line", got_fill_line[0], 128'h100003FF_100003FE_100003FD_100003FC);

        // Flush in DONE together with fill_ready: line dropped.
        clear_logs();
        cycle(1'b1, 10'h200, 1'b0, 1'b0);
        repeat (LINE_WORDS + 1) cycle(1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("flush_done_xfers", LW'(got_fill_addr.size()), LW'(0));

        // Asynchronous reset between edges, mid-FETCH.
        cycle(1'b1, 10'h155, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_reset_outputs("arst");
        m_busy = 1'b0;
        m_last = '0;
        @(negedge clock);
        reset = 1'b0;
        clear_logs();
        cycle(1'b1, 10'h000, 1'b0, 1'b1);
        repeat (8) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("arst_latency", LW'(first_fill - acc_cyc), LW'(LINE_WORDS + 1));
        chk("arst_fill_addr", LW'(got_fill_addr[0]), LW'(0));
        chk("arst_line", got_fill_line[0], 128'h10000003_10000002_10000001_10000000);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 2) != 0));
        end
        repeat (LINE_WORDS + 2) cycle(1'b0, '0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
